// File: rtl/load_align_unit.sv
// -----------------------------------------------------------------------------
// load_align_unit
//
// Load data path between the MEM stage and a beat-wide data memory port.
// A request is decoded, turned into one beat read (or two when the access
// straddles a beat boundary), and the returned beats are shifted, merged and
// sign/zero-extended to XLEN. The result leaves over a valid/ready handshake.
// Only one transaction is ever in flight.
//
// Parameters
//   XLEN        beat and result width, 32 or 64 (B = XLEN/8 bytes per beat)
//   MISALIGN_EN 1: split boundary-crossing loads, 0: misaligned load -> error
//   ADDR_W      byte address width
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   flush                abort the current transaction
//   req_valid/req_ready  load request handshake
//   req_addr             byte address
//   req_funct3           RISC-V load funct3
//   req_rd               destination tag, returned unchanged on rsp_rd
//   mem_req_valid/ready  beat read request handshake
//   mem_req_addr         beat-aligned read address
//   mem_rsp_valid/data   beat read data, one per accepted request, in order
//   rsp_valid/rsp_ready  result handshake
//   rsp_data             extended load result
//   rsp_rd               destination tag
//   rsp_err              illegal funct3, or misaligned load with MISALIGN_EN=0
// -----------------------------------------------------------------------------
module load_align_unit #(
  parameter int XLEN        = 32,
  parameter bit MISALIGN_EN = 1'b1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [4:0]        req_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_err
);

  localparam int B  = XLEN / 8;
  localparam int OW = $clog2(B);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_WAIT0,
    S_RD1,
    S_WAIT1,
    S_RESP,
    S_DRAIN
  } state_e;

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  function automatic logic is_legal(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
      3'b011, 3'b110:                         return (XLEN == 64);
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] size_of(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction

  // Shift the two-beat window down by the byte offset, keep the access size
  // and extend from its top bit. beat1 is passed as zero for a single beat.
  function automatic logic [XLEN-1:0] align_ext(input logic [XLEN-1:0] hi,
                                                 input logic [XLEN-1:0] lo,
                                                 input logic [OW-1:0]   off,
                                                 input logic [2:0]      f3);
    logic [2*XLEN-1:0] win;
    logic [XLEN-1:0]   res;
    logic              sbit;
    int                nbits;
    win   = {hi, lo} >> {off, 3'b000};
    res   = win[XLEN-1:0];
    nbits = 8 << f3[1:0];
    sbit  = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      if (i == nbits - 1) sbit = res[i] & ~f3[2];
    end
    for (int i = 0; i < XLEN; i++) begin
      if (i >= nbits) res[i] = sbit;
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q,    state_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [2:0]        f3_q,       f3_d;
  logic [4:0]        rd_q,       rd_d;
  logic [XLEN-1:0]   beat0_q,    beat0_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic              rsp_err_q,  rsp_err_d;

  // Incoming request decode
  logic [OW-1:0] req_off;
  logic [3:0]    req_size;
  logic          req_legal;
  logic          req_mis;

  assign req_off   = req_addr[OW-1:0];
  assign req_size  = size_of(req_funct3);
  assign req_legal = is_legal(req_funct3);
  assign req_mis   = ((4'(req_off) & (req_size - 4'd1)) != 4'd0);

  // Latched request decode
  logic [OW-1:0]     off_q;
  logic              split;
  logic [ADDR_W-1:0] beat_base;

  assign off_q     = addr_q[OW-1:0];
  assign split     = (5'(off_q) + 5'(size_of(f3_q))) > 5'(B);
  assign beat_base = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    f3_d       = f3_q;
    rd_d       = rd_q;
    beat0_d    = beat0_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (!flush && req_valid) begin
          addr_d = req_addr;
          f3_d   = req_funct3;
          rd_d   = req_rd;
          if (!req_legal || (req_mis && !MISALIGN_EN)) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = S_RESP;
          end else begin
            rsp_err_d = 1'b0;
            state_d   = S_RD0;
          end
        end
      end

      // A flush that coincides with the beat handshake still leaves a
      // response on its way, so it must be drained.
      S_RD0: begin
        if (mem_req_ready) state_d = flush ? S_DRAIN : S_WAIT0;
        else if (flush)    state_d = S_IDLE;
      end

      S_WAIT0: begin
        if (mem_rsp_valid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else if (split) begin
            beat0_d = mem_rsp_data;
            state_d = S_RD1;
          end else begin
            rsp_data_d = align_ext('0, mem_rsp_data, off_q, f3_q);
            state_d    = S_RESP;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end

      S_RD1: begin
        if (mem_req_ready) state_d = flush ? S_DRAIN : S_WAIT1;
        else if (flush)    state_d = S_IDLE;
      end

      S_WAIT1: begin
        if (mem_rsp_valid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            rsp_data_d = align_ext(mem_rsp_data, beat0_q, off_q, f3_q);
            state_d    = S_RESP;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end

      S_RESP: begin
        if (flush || rsp_ready) state_d = S_IDLE;
      end

      // The outstanding response is dropped on arrival; a further flush
      // changes nothing because the beat is still owed.
      S_DRAIN: begin
        if (mem_rsp_valid) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state and datapath registers all take the asynchronous reset so the
  // registered outputs read zero while rst is low; non-blocking assignments
  // keep every register updating from the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      beat0_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      f3_q       <= f3_d;
      rd_q       <= rd_d;
      beat0_q    <= beat0_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // A flush in IDLE refuses the request so it is never half-accepted.
  assign req_ready     = rst && (state_q == S_IDLE) && !flush;
  assign mem_req_valid = (state_q == S_RD0) || (state_q == S_RD1);
  assign mem_req_addr  = (state_q == S_RD0) ? beat_base :
                         (state_q == S_RD1) ? beat_base + ADDR_W'(B) :
                                              '0;
  assign rsp_valid     = (state_q == S_RESP);
  assign rsp_data      = rsp_data_q;
  assign rsp_rd        = rd_q;
  assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// -----------------------------------------------------------------------------
// tb_load_align_unit
//
// Three instances of load_align_unit:
//   a: XLEN=32, MISALIGN_EN=1  table of loads plus flush/backpressure/reset
//   b: XLEN=32, MISALIGN_EN=0  misaligned loads become errors
//   c: XLEN=64, MISALIGN_EN=1  LWU/LW/LD on a 64-bit beat
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_load_align_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Instance a
  // ---------------------------------------------------------------------------
  logic        a_flush, a_req_valid, a_req_ready;
  logic [31:0] a_req_addr;
  logic [2:0]  a_req_funct3;
  logic [4:0]  a_req_rd;
  logic        a_mem_req_valid, a_mem_req_ready;
  logic [31:0] a_mem_req_addr;
  logic        a_mem_rsp_valid = 1'b0;
  logic [31:0] a_mem_rsp_data  = '0;
  logic        a_rsp_valid, a_rsp_ready;
  logic [31:0] a_rsp_data;
  logic [4:0]  a_rsp_rd;
  logic        a_rsp_err;

  load_align_unit #(.XLEN(32), .MISALIGN_EN(1'b1), .ADDR_W(32)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
    .req_funct3(a_req_funct3), .req_rd(a_req_rd),
    .mem_req_valid(a_mem_req_valid), .mem_req_ready(a_mem_req_ready),
    .mem_req_addr(a_mem_req_addr), .mem_rsp_valid(a_mem_rsp_valid),
    .mem_rsp_data(a_mem_rsp_data), .rsp_valid(a_rsp_valid),
    .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data), .rsp_rd(a_rsp_rd),
    .rsp_err(a_rsp_err)
  );

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    case (a)
      32'h100: return 32'h80FF_1234;
      32'h200: return 32'hAB00_0000;
      32'h204: return 32'h0000_00CD;
      32'h300: return 32'h8765_4321;
      32'h304: return 32'h1122_3344;
      default: return 32'h0;
    endcase
  endfunction

  // Memory model for instance a: answers each accepted beat request
  // 1 + a_delay cycles later and logs the request addresses.
  int          a_delay = 0;
  int          a_cnt   = 0;
  logic [31:0] a_pend_addr = '0;
  logic [31:0] a_log[$];

  always @(negedge clk) begin
    a_mem_rsp_valid = 1'b0;
    if (a_cnt > 0) begin
      a_cnt--;
      if (a_cnt == 0) begin
        a_mem_rsp_valid = 1'b1;
        a_mem_rsp_data  = mem_read(a_pend_addr);
      end
    end
    if (a_mem_req_valid && a_mem_req_ready) begin
      a_log.push_back(a_mem_req_addr);
      a_pend_addr = a_mem_req_addr;
      a_cnt       = 1 + a_delay;
    end
  end

  function automatic logic [31:0] log_at(input int idx);
    if (idx < a_log.size()) return a_log[idx];
    return 32'hFFFF_FFFF;
  endfunction

  // One complete transaction on instance a, started on a falling edge with
  // the unit idle. lat counts rising edges from request to rsp_valid.
  task automatic a_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                        output logic [31:0] data, output logic err, output logic [4:0] rdo,
                        output int lat);
    a_req_valid  = 1'b1;
    a_req_addr   = addr;
    a_req_funct3 = f3;
    a_req_rd     = rd;
    @(negedge clk);
    a_req_valid = 1'b0;
    lat = 1;
    while (!a_rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    data = a_rsp_data;
    err  = a_rsp_err;
    rdo  = a_rsp_rd;
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          nreq;
    logic [31:0] beat;
  } vec_t;

  vec_t vecs[13];

  // ---------------------------------------------------------------------------
  // Instance b
  // ---------------------------------------------------------------------------
  logic        b_flush, b_req_valid, b_req_ready;
  logic [31:0] b_req_addr;
  logic [2:0]  b_req_funct3;
  logic [4:0]  b_req_rd;
  logic        b_mem_req_valid, b_mem_req_ready;
  logic [31:0] b_mem_req_addr;
  logic        b_mem_rsp_valid;
  logic [31:0] b_mem_rsp_data;
  logic        b_rsp_valid, b_rsp_ready;
  logic [31:0] b_rsp_data;
  logic [4:0]  b_rsp_rd;
  logic        b_rsp_err;
  logic        b_saw_mem = 1'b0;

  load_align_unit #(.XLEN(32), .MISALIGN_EN(1'b0), .ADDR_W(32)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .req_funct3(b_req_funct3), .req_rd(b_req_rd),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready),
    .mem_req_addr(b_mem_req_addr), .mem_rsp_valid(b_mem_rsp_valid),
    .mem_rsp_data(b_mem_rsp_data), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_rd(b_rsp_rd),
    .rsp_err(b_rsp_err)
  );

  always @(posedge clk) if (b_mem_req_valid === 1'b1) b_saw_mem <= 1'b1;

  task automatic b_err(input string name, input logic [31:0] addr, input logic [2:0] f3);
    b_req_valid  = 1'b1;
    b_req_addr   = addr;
    b_req_funct3 = f3;
    b_req_rd     = 5'd3;
    @(negedge clk);
    b_req_valid = 1'b0;
    check({name, " rsp_valid"}, b_rsp_valid, 1'b1);
    check({name, " rsp_err"},   b_rsp_err,   1'b1);
    check({name, " rsp_data"},  b_rsp_data,  32'h0);
    b_rsp_ready = 1'b1;
    @(negedge clk);
    b_rsp_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Instance c
  // ---------------------------------------------------------------------------
  logic        c_flush, c_req_valid, c_req_ready;
  logic [31:0] c_req_addr;
  logic [2:0]  c_req_funct3;
  logic [4:0]  c_req_rd;
  logic        c_mem_req_valid, c_mem_req_ready;
  logic [31:0] c_mem_req_addr;
  logic        c_mem_rsp_valid;
  logic [63:0] c_mem_rsp_data;
  logic        c_rsp_valid, c_rsp_ready;
  logic [63:0] c_rsp_data;
  logic [4:0]  c_rsp_rd;
  logic        c_rsp_err;

  load_align_unit #(.XLEN(64), .MISALIGN_EN(1'b1), .ADDR_W(32)) u_c (
    .clk(clk), .rst(rst), .flush(c_flush),
    .req_valid(c_req_valid), .req_ready(c_req_ready), .req_addr(c_req_addr),
    .req_funct3(c_req_funct3), .req_rd(c_req_rd),
    .mem_req_valid(c_mem_req_valid), .mem_req_ready(c_mem_req_ready),
    .mem_req_addr(c_mem_req_addr), .mem_rsp_valid(c_mem_rsp_valid),
    .mem_rsp_data(c_mem_rsp_data), .rsp_valid(c_rsp_valid),
    .rsp_ready(c_rsp_ready), .rsp_data(c_rsp_data), .rsp_rd(c_rsp_rd),
    .rsp_err(c_rsp_err)
  );

  // Single-beat load on instance c with a zero-wait hand-driven response.
  task automatic c_load(input string name, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [63:0] beat, input logic [31:0] exp_maddr,
                        input logic [63:0] exp_data);
    c_req_valid  = 1'b1;
    c_req_addr   = addr;
    c_req_funct3 = f3;
    c_req_rd     = 5'd21;
    @(negedge clk);
    c_req_valid = 1'b0;
    check({name, " mem_req_valid"}, c_mem_req_valid, 1'b1);
    check({name, " mem_req_addr"},  c_mem_req_addr,  exp_maddr);
    @(negedge clk);
    c_mem_rsp_valid = 1'b1;
    c_mem_rsp_data  = beat;
    @(negedge clk);
    c_mem_rsp_valid = 1'b0;
    check({name, " rsp_valid"}, c_rsp_valid, 1'b1);
    check({name, " rsp_data"},  c_rsp_data,  exp_data);
    check({name, " rsp_err"},   c_rsp_err,   1'b0);
    c_rsp_ready = 1'b1;
    @(negedge clk);
    c_rsp_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] d;
    logic        e;
    logic [4:0]  r;
    int          lat;
    int          start;

    rst = 1'b1;
    a_flush = 0; a_req_valid = 0; a_req_addr = '0; a_req_funct3 = '0; a_req_rd = '0;
    a_mem_req_ready = 1; a_rsp_ready = 0;
    b_flush = 0; b_req_valid = 0; b_req_addr = '0; b_req_funct3 = '0; b_req_rd = '0;
    b_mem_req_ready = 1; b_mem_rsp_valid = 0; b_mem_rsp_data = '0; b_rsp_ready = 0;
    c_flush = 0; c_req_valid = 0; c_req_addr = '0; c_req_funct3 = '0; c_req_rd = '0;
    c_mem_req_ready = 1; c_mem_rsp_valid = 0; c_mem_rsp_data = '0; c_rsp_ready = 0;
    #1 rst = 1'b0;

    //                  addr      f3      data           err   lat nreq beat
    vecs[0]  = '{32'h103, 3'b000, 32'hFFFF_FF80, 1'b0, 3, 1, 32'h100}; // LB
    vecs[1]  = '{32'h203, 3'b101, 32'h0000_CDAB, 1'b0, 5, 2, 32'h200}; // LHU split
    vecs[2]  = '{32'h103, 3'b100, 32'h0000_0080, 1'b0, 3, 1, 32'h100}; // LBU
    vecs[3]  = '{32'h100, 3'b001, 32'h0000_1234, 1'b0, 3, 1, 32'h100}; // LH +
    vecs[4]  = '{32'h102, 3'b001, 32'hFFFF_80FF, 1'b0, 3, 1, 32'h100}; // LH -
    vecs[5]  = '{32'h300, 3'b010, 32'h8765_4321, 1'b0, 3, 1, 32'h300}; // LW
    vecs[6]  = '{32'h302, 3'b010, 32'h3344_8765, 1'b0, 5, 2, 32'h300}; // LW split
    vecs[7]  = '{32'h301, 3'b001, 32'h0000_6543, 1'b0, 3, 1, 32'h300}; // LH mis, in beat
    vecs[8]  = '{32'h300, 3'b011, 32'h0000_0000, 1'b1, 1, 0, 32'h0};   // LD illegal
    vecs[9]  = '{32'h300, 3'b111, 32'h0000_0000, 1'b1, 1, 0, 32'h0};   // 111 illegal
    vecs[10] = '{32'h300, 3'b110, 32'h0000_0000, 1'b1, 1, 0, 32'h0};   // LWU illegal
    vecs[11] = '{32'h303, 3'b101, 32'h0000_4487, 1'b0, 5, 2, 32'h300}; // LHU split
    vecs[12] = '{32'h307, 3'b000, 32'h0000_0011, 1'b0, 3, 1, 32'h304}; // LB 2nd beat

    // Reset state
    @(negedge clk);
    check("reset req_ready",     a_req_ready,     1'b0);
    check("reset mem_req_valid", a_mem_req_valid, 1'b0);
    check("reset mem_req_addr",  a_mem_req_addr,  32'h0);
    check("reset rsp_valid",     a_rsp_valid,     1'b0);
    check("reset rsp_data",      a_rsp_data,      32'h0);
    check("reset rsp_rd",        a_rsp_rd,        5'h0);
    check("reset rsp_err",       a_rsp_err,       1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("post-reset req_ready", a_req_ready, 1'b1);

    // Table-driven loads on instance a
    for (int i = 0; i < 13; i++) begin
      start = a_log.size();
      a_load(vecs[i].addr, vecs[i].f3, 5'(i + 1), d, e, r, lat);
      check($sformatf("v%0d rsp_data", i), d, vecs[i].data);
      check($sformatf("v%0d rsp_err", i),  e, vecs[i].err);
      check($sformatf("v%0d rsp_rd", i),   r, 5'(i + 1));
      check($sformatf("v%0d latency", i),  lat, vecs[i].lat);
      check($sformatf("v%0d mem reqs", i), a_log.size() - start, vecs[i].nreq);
      if (vecs[i].nreq >= 1)
        check($sformatf("v%0d beat0 addr", i), log_at(start), vecs[i].beat);
      if (vecs[i].nreq >= 2)
        check($sformatf("v%0d beat1 addr", i), log_at(start + 1), vecs[i].beat + 32'h4);
    end

    // Flush in WAIT0, memory answers one cycle after the flush
    a_delay = 1;
    a_req_valid = 1'b1; a_req_addr = 32'h300; a_req_funct3 = 3'b010; a_req_rd = 5'd7;
    @(negedge clk);
    a_req_valid = 1'b0;
    @(negedge clk);
    check("flush wait0 rsp_valid", a_rsp_valid, 1'b0);
    a_flush = 1'b1;
    @(negedge clk);
    a_flush = 1'b0;
    check("drain req_ready", a_req_ready, 1'b0);
    check("drain rsp_valid", a_rsp_valid, 1'b0);
    @(negedge clk);
    a_delay = 0;
    check("after drain req_ready", a_req_ready, 1'b1);
    check("after drain rsp_valid", a_rsp_valid, 1'b0);
    @(negedge clk);
    check("after drain idle rsp_valid", a_rsp_valid, 1'b0);
    a_load(32'h100, 3'b010, 5'd8, d, e, r, lat);
    check("post-flush LW data", d, 32'h80FF_1234);
    check("post-flush LW rd",   r, 5'd8);

    // rsp_ready held low for 5 cycles
    a_req_valid = 1'b1; a_req_addr = 32'h300; a_req_funct3 = 3'b010; a_req_rd = 5'd9;
    @(negedge clk);
    a_req_valid = 1'b0;
    lat = 1;
    while (!a_rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("hold first rsp_valid", a_rsp_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d rsp_valid", k), a_rsp_valid, 1'b1);
      check($sformatf("hold%0d rsp_data", k),  a_rsp_data,  32'h8765_4321);
      check($sformatf("hold%0d rsp_rd", k),    a_rsp_rd,    5'd9);
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    check("hold release rsp_valid", a_rsp_valid, 1'b0);

    // Asynchronous reset while waiting in RD1
    a_req_valid = 1'b1; a_req_addr = 32'h302; a_req_funct3 = 3'b010; a_req_rd = 5'd11;
    @(negedge clk);
    a_req_valid = 1'b0;
    @(negedge clk);
    a_mem_req_ready = 1'b0;
    @(negedge clk);
    check("rd1 mem_req_valid", a_mem_req_valid, 1'b1);
    check("rd1 mem_req_addr",  a_mem_req_addr,  32'h304);
    #2 rst = 1'b0;
    #1;
    check("mid-rst req_ready",     a_req_ready,     1'b0);
    check("mid-rst mem_req_valid", a_mem_req_valid, 1'b0);
    check("mid-rst mem_req_addr",  a_mem_req_addr,  32'h0);
    check("mid-rst rsp_valid",     a_rsp_valid,     1'b0);
    check("mid-rst rsp_data",      a_rsp_data,      32'h0);
    check("mid-rst rsp_rd",        a_rsp_rd,        5'h0);
    check("mid-rst rsp_err",       a_rsp_err,       1'b0);
    @(negedge clk);
    rst = 1'b1;
    a_mem_req_ready = 1'b1;
    @(negedge clk);
    check("after mid-rst req_ready", a_req_ready, 1'b1);

    // Instance b: misaligned loads are errors, aligned loads still work
    b_err("b LW 0x002", 32'h002, 3'b010);
    b_err("b LH 0x001", 32'h001, 3'b001);
    check("b no mem access", b_saw_mem, 1'b0);
    b_req_valid = 1'b1; b_req_addr = 32'h008; b_req_funct3 = 3'b010; b_req_rd = 5'd4;
    @(negedge clk);
    b_req_valid = 1'b0;
    check("b LW mem_req_valid", b_mem_req_valid, 1'b1);
    check("b LW mem_req_addr",  b_mem_req_addr,  32'h008);
    @(negedge clk);
    b_mem_rsp_valid = 1'b1; b_mem_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    b_mem_rsp_valid = 1'b0;
    check("b LW rsp_data", b_rsp_data, 32'hDEAD_BEEF);
    check("b LW rsp_err",  b_rsp_err,  1'b0);
    b_rsp_ready = 1'b1;
    @(negedge clk);
    b_rsp_ready = 1'b0;

    // Instance c: 64-bit beats
    c_load("c LWU 0x4", 32'h4, 3'b110, 64'h8765_4321_0000_0000, 32'h0, 64'h0000_0000_8765_4321);
    c_load("c LW 0x4",  32'h4, 3'b010, 64'h8765_4321_0000_0000, 32'h0, 64'hFFFF_FFFF_8765_4321);
    c_load("c LD 0x8",  32'h8, 3'b011, 64'h0123_4567_89AB_CDEF, 32'h8, 64'h0123_4567_89AB_CDEF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
